u_ins_loader: RTL and testbench
===============================

U_INS_LOADER -- requirements
Module: u_ins_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 The block SHALL have parameter DEPTH, default 256, instruction memory depth in words, power of two, at least 4.
REQ-003 The block SHALL have parameter BOOT_ADDR, default 32'h0000_0000, byte address of word 0, word aligned.
REQ-004 The block SHALL have port i_sys_clock, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_sys_reset, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have port i_u_ins_loader_start, input, 1, one-cycle pulse that begins or restarts a load.
REQ-007 The block SHALL have port i_u_ins_loader_ins, input, DATA_W, incoming instruction word.
REQ-008 The block SHALL have port i_u_ins_loader_valid, input, 1, incoming word present.
REQ-009 The block SHALL have port i_u_ins_loader_last, input, 1, qualifies the current word as the final word of the image.
REQ-010 The block SHALL have port o_u_ins_loader_ready, output, 1, loader can accept a word.
REQ-011 The block SHALL have port o_u_ins_loader_mem_wr, output, 1, instruction memory write enable.
REQ-012 The block SHALL have port o_u_ins_loader_mem_addr, output, 32, instruction memory byte address.
REQ-013 The block SHALL have port o_u_ins_loader_mem_data, output, DATA_W, instruction memory write data.
REQ-014 The block SHALL have port o_u_ins_loader_cpu_reset_n, output, 1, CPU reset; low holds the CPU in reset.
REQ-015 The block SHALL have port o_u_ins_loader_count, output, clog2(DEPTH)+1, number of words accepted in the current load.
REQ-016 The block SHALL have port o_u_ins_loader_done, output, 1, image loaded and CPU running.
REQ-017 The block SHALL have port o_u_ins_loader_overflow, output, 1, sticky image-too-large error.

Function
REQ-018 The loader SHALL implement FSM states IDLE, LOAD, DRAIN, RUN and ERROR.
REQ-019 State transitions SHALL be:
- IDLE to LOAD on start.
- LOAD to DRAIN on an accepted word with last=1.
- LOAD to ERROR when count==DEPTH and valid=1.
- DRAIN to RUN unconditionally after 1 cycle.
- RUN and ERROR to LOAD on start.
REQ-020 A word SHALL be accepted on a rising edge where valid=1 and ready=1.
REQ-021 ready SHALL be 1 only in LOAD with count<DEPTH and start=0, combinationally.
REQ-022 Each accepted word k (0-based) SHALL produce exactly one mem_wr=1 cycle on the next cycle, with:
- mem_addr = BOOT_ADDR + 4*k, 32-bit modulo arithmetic.
- mem_data = the accepted word.
REQ-023 mem_wr SHALL be 0 in every cycle without a pending write; mem_addr and mem_data hold their last values when mem_wr=0.
REQ-024 count SHALL increment by 1 per accepted word, saturate at DEPTH, and clear to 0 on the edge where start is sampled.
REQ-025 start SHALL take priority over valid in the same cycle: that word is discarded and count becomes 0.
REQ-026 cpu_reset_n SHALL be 1 only in RUN; it goes low on the cycle after start is sampled in RUN.
REQ-027 done SHALL equal 1 exactly while in RUN.
REQ-028 overflow SHALL set on entry to ERROR and clear only on start or reset; ERROR holds ready=0 and issues no writes.
REQ-029 A word accepted with count==DEPTH-1 and last=1 SHALL complete normally, with no overflow.
REQ-030 valid while in IDLE, DRAIN, RUN or ERROR SHALL be ignored, with no writes and no count change.
REQ-031 A start pulse in DRAIN SHALL be ignored, except that the write pending from the last accepted word still issues.

Reset
REQ-032 When i_sys_reset=0 at a rising edge, the next state SHALL be: IDLE, count=0, mem_wr=0, mem_addr=BOOT_ADDR, mem_data=0, ready=0, cpu_reset_n=0, done=0, overflow=0.
REQ-033 Reset SHALL take priority over start and valid, and SHALL cancel any pending write, including reset mid-LOAD or mid-DRAIN.

Verification
REQ-034 Basic load: DEPTH=256; start, then 3 words 0x20080005, 0x20090007, 0x01095020 with last on the third -> writes at 0x0, 0x4, 0x8, one cycle after each acceptance; DRAIN 1 cycle; then cpu_reset_n=1, done=1, count=3.
REQ-035 Full image: DEPTH=4; 4 words, last on the 4th -> writes at 0x0 to 0xC; RUN reached; overflow=0.
REQ-036 Overflow: DEPTH=4; 5 words, no last -> ready=0 after the 4th; ERROR entered; overflow=1; cpu_reset_n stays 0; a following start clears overflow and count.
REQ-037 Start collision: start and valid in the same cycle during LOAD after 2 words -> that word is not written; count=0; the next word writes at BOOT_ADDR.
REQ-038 Reload from RUN and reset: start in RUN -> cpu_reset_n=0 next cycle, done=0. Separately, reset asserted the same cycle a word is accepted -> no write next cycle and all outputs at their REQ-032 values.

Source files
------------

// File: rtl/u_ins_loader_if.sv
// Handshake and instruction-memory bus between an image source and the loader.
// The loader side takes the slave modport, the image source the master modport.
interface u_ins_loader_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Image stream from the source into the loader.
  logic              i_u_ins_loader_start;
  logic [DATA_W-1:0] i_u_ins_loader_ins;
  logic              i_u_ins_loader_valid;
  logic              i_u_ins_loader_last;

  // Loader responses: flow control, memory write port, CPU control and status.
  logic              o_u_ins_loader_ready;
  logic              o_u_ins_loader_mem_wr;
  logic [31:0]       o_u_ins_loader_mem_addr;
  logic [DATA_W-1:0] o_u_ins_loader_mem_data;
  logic              o_u_ins_loader_cpu_reset_n;
  logic [CNT_W-1:0]  o_u_ins_loader_count;
  logic              o_u_ins_loader_done;
  logic              o_u_ins_loader_overflow;

  modport master (
    output i_u_ins_loader_start,
    output i_u_ins_loader_ins,
    output i_u_ins_loader_valid,
    output i_u_ins_loader_last,
    input  o_u_ins_loader_ready,
    input  o_u_ins_loader_mem_wr,
    input  o_u_ins_loader_mem_addr,
    input  o_u_ins_loader_mem_data,
    input  o_u_ins_loader_cpu_reset_n,
    input  o_u_ins_loader_count,
    input  o_u_ins_loader_done,
    input  o_u_ins_loader_overflow
  );

  modport slave (
    input  i_u_ins_loader_start,
    input  i_u_ins_loader_ins,
    input  i_u_ins_loader_valid,
    input  i_u_ins_loader_last,
    output o_u_ins_loader_ready,
    output o_u_ins_loader_mem_wr,
    output o_u_ins_loader_mem_addr,
    output o_u_ins_loader_mem_data,
    output o_u_ins_loader_cpu_reset_n,
    output o_u_ins_loader_count,
    output o_u_ins_loader_done,
    output o_u_ins_loader_overflow
  );
endinterface

// File: rtl/u_ins_loader.sv
// Instruction image loader: accepts a word stream, writes it to instruction
// memory from BOOT_ADDR upward, then releases the CPU from reset. An image
// larger than DEPTH words parks the loader in a sticky error state.
module u_ins_loader #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic            i_sys_clock,
  input  logic            i_sys_reset,
  u_ins_loader_if.slave   ldr
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  logic              mem_wr_q;
  logic [31:0]       mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              cpu_reset_n_q;
  logic              done_q;
  logic              overflow_q;

  logic              ready_s;
  logic              accept_s;
  logic [31:0]       count_ext_s;
  logic [31:0]       wr_addr_d;

  // Flow control and the byte address the next accepted word will land at;
  // a start in the same cycle always wins over an incoming word.
  always_comb begin
    ready_s     = 1'b0;
    accept_s    = 1'b0;
    count_ext_s = 32'(count_q);
    if ((state_q == S_LOAD) && (count_q < DEPTH_C) && !ldr.i_u_ins_loader_start) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s  = ready_s & ldr.i_u_ins_loader_valid;
    wr_addr_d = BOOT_ADDR + (count_ext_s << 5'd2);
  end

  // Loader FSM with registered memory write port and CPU control outputs.
  always_ff @(posedge i_sys_clock) begin
    if (!i_sys_reset) begin
      state_q       <= S_IDLE;
      count_q       <= {CNT_W{1'b0}};
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= BOOT_ADDR;
      mem_data_q    <= {DATA_W{1'b0}};
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ldr.i_u_ins_loader_start) begin
            state_q <= S_LOAD;
            count_q <= {CNT_W{1'b0}};
          end
        end
        S_LOAD: begin
          if (ldr.i_u_ins_loader_start) begin
            count_q <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= wr_addr_d;
            mem_data_q <= ldr.i_u_ins_loader_ins;
            count_q    <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (ldr.i_u_ins_loader_last) begin
              state_q <= S_DRAIN;
            end
          end else if (ldr.i_u_ins_loader_valid && (count_q == DEPTH_C)) begin
            // Memory already full and the source still has data: image too large.
            state_q    <= S_ERROR;
            overflow_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          // The final word's write is on the bus this cycle; start is ignored.
          state_q       <= S_RUN;
          cpu_reset_n_q <= 1'b1;
          done_q        <= 1'b1;
        end
        S_RUN: begin
          if (ldr.i_u_ins_loader_start) begin
            state_q       <= S_LOAD;
            count_q       <= {CNT_W{1'b0}};
            cpu_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
          end
        end
        S_ERROR: begin
          if (ldr.i_u_ins_loader_start) begin
            state_q    <= S_LOAD;
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          count_q       <= {CNT_W{1'b0}};
          cpu_reset_n_q <= 1'b0;
          done_q        <= 1'b0;
          overflow_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ldr.o_u_ins_loader_ready       = ready_s;
  assign ldr.o_u_ins_loader_mem_wr      = mem_wr_q;
  assign ldr.o_u_ins_loader_mem_addr    = mem_addr_q;
  assign ldr.o_u_ins_loader_mem_data    = mem_data_q;
  assign ldr.o_u_ins_loader_cpu_reset_n = cpu_reset_n_q;
  assign ldr.o_u_ins_loader_count       = count_q;
  assign ldr.o_u_ins_loader_done        = done_q;
  assign ldr.o_u_ins_loader_overflow    = overflow_q;

endmodule

// File: tb/tb_u_ins_loader.sv
// Bench for u_ins_loader: two instances (DEPTH=256 and DEPTH=4) share one
// stimulus stream; a constant vector table, directed corner sequences and a
// random run are checked against a behavioural reference model.
module tb_u_ins_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_s;
  logic        valid_s;
  logic        last_s;
  logic [31:0] ins_s;

  u_ins_loader_if #(.DATA_W(32), .DEPTH(256)) bus_a ();
  u_ins_loader_if #(.DATA_W(32), .DEPTH(4))   bus_b ();

  assign bus_a.i_u_ins_loader_start = start_s;
  assign bus_a.i_u_ins_loader_ins   = ins_s;
  assign bus_a.i_u_ins_loader_valid = valid_s;
  assign bus_a.i_u_ins_loader_last  = last_s;
  assign bus_b.i_u_ins_loader_start = start_s;
  assign bus_b.i_u_ins_loader_ins   = ins_s;
  assign bus_b.i_u_ins_loader_valid = valid_s;
  assign bus_b.i_u_ins_loader_last  = last_s;

  u_ins_loader #(.DATA_W(32), .DEPTH(256), .BOOT_ADDR(32'h0000_0000)) dut_a (
    .i_sys_clock (clk),
    .i_sys_reset (rst_n),
    .ldr         (bus_a.slave)
  );

  u_ins_loader #(.DATA_W(32), .DEPTH(4), .BOOT_ADDR(32'h0000_0000)) dut_b (
    .i_sys_clock (clk),
    .i_sys_reset (rst_n),
    .ldr         (bus_b.slave)
  );

  // Observed outputs gathered per instance (index 0: DEPTH 256, 1: DEPTH 4).
  logic        o_rdy [2];
  logic        o_wr  [2];
  logic [31:0] o_addr[2];
  logic [31:0] o_data[2];
  logic        o_cpu [2];
  logic [31:0] o_cnt [2];
  logic        o_done[2];
  logic        o_ovf [2];

  assign o_rdy[0]  = bus_a.o_u_ins_loader_ready;
  assign o_wr[0]   = bus_a.o_u_ins_loader_mem_wr;
  assign o_addr[0] = bus_a.o_u_ins_loader_mem_addr;
  assign o_data[0] = bus_a.o_u_ins_loader_mem_data;
  assign o_cpu[0]  = bus_a.o_u_ins_loader_cpu_reset_n;
  assign o_cnt[0]  = 32'(bus_a.o_u_ins_loader_count);
  assign o_done[0] = bus_a.o_u_ins_loader_done;
  assign o_ovf[0]  = bus_a.o_u_ins_loader_overflow;
  assign o_rdy[1]  = bus_b.o_u_ins_loader_ready;
  assign o_wr[1]   = bus_b.o_u_ins_loader_mem_wr;
  assign o_addr[1] = bus_b.o_u_ins_loader_mem_addr;
  assign o_data[1] = bus_b.o_u_ins_loader_mem_data;
  assign o_cpu[1]  = bus_b.o_u_ins_loader_cpu_reset_n;
  assign o_cnt[1]  = 32'(bus_b.o_u_ins_loader_count);
  assign o_done[1] = bus_b.o_u_ins_loader_done;
  assign o_ovf[1]  = bus_b.o_u_ins_loader_overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: what phase of the load each instance is in, how many
  // words it has taken, and the last write it put on the memory bus.
  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_RUN = 3, M_ERR = 4;
  int          dep[2] = '{256, 4};
  int          m_mode[2];
  int          m_n[2];
  bit          m_wr[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_data[2];
  bit          m_ovf[2];
  bit          known = 1'b0;

  bit          cur_r, cur_s, cur_v, cur_l;
  logic [31:0] cur_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!cur_r) begin
        m_mode[d] = M_IDLE; m_n[d] = 0; m_wr[d] = 1'b0;
        m_addr[d] = 32'h0; m_data[d] = 32'h0; m_ovf[d] = 1'b0;
      end else begin
        m_wr[d] = 1'b0;
        if (m_mode[d] == M_DRAIN) begin
          m_mode[d] = M_RUN;
        end else if (cur_s) begin
          m_mode[d] = M_LOAD; m_n[d] = 0; m_ovf[d] = 1'b0;
        end else if (m_mode[d] == M_LOAD && cur_v) begin
          if (m_n[d] < dep[d]) begin
            m_wr[d]   = 1'b1;
            m_addr[d] = 32'(4 * m_n[d]);
            m_data[d] = cur_w;
            m_n[d]    = m_n[d] + 1;
            if (cur_l) m_mode[d] = M_DRAIN;
          end else begin
            m_mode[d] = M_ERR; m_ovf[d] = 1'b1;
          end
        end
      end
    end
    known = 1'b1;
  endtask

  // Set inputs, let them settle, then check the combinational ready.
  task automatic apply(input bit r, input bit s, input bit v, input bit l, input logic [31:0] w);
    cur_r = r; cur_s = s; cur_v = v; cur_l = l; cur_w = w;
    rst_n = r; start_s = s; valid_s = v; last_s = l; ins_s = w;
    #2;
    if (known) begin
      for (int d = 0; d < 2; d++)
        chk($sformatf("model_ready[%0d]", d), 32'(o_rdy[d]),
            32'((m_mode[d] == M_LOAD) && (m_n[d] < dep[d]) && !s));
    end
  endtask

  // Clock the inputs in and check all registered outputs against the model.
  task automatic clock_edge();
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("model_wr[%0d]", d),   32'(o_wr[d]),   32'(m_wr[d]));
      chk($sformatf("model_addr[%0d]", d), o_addr[d],      m_addr[d]);
      chk($sformatf("model_data[%0d]", d), o_data[d],      m_data[d]);
      chk($sformatf("model_cnt[%0d]", d),  o_cnt[d],       32'(m_n[d]));
      chk($sformatf("model_cpu[%0d]", d),  32'(o_cpu[d]),  32'(m_mode[d] == M_RUN));
      chk($sformatf("model_done[%0d]", d), 32'(o_done[d]), 32'(m_mode[d] == M_RUN));
      chk($sformatf("model_ovf[%0d]", d),  32'(o_ovf[d]),  32'(m_ovf[d]));
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input bit l, input logic [31:0] w);
    apply(r, s, v, l, w);
    clock_edge();
  endtask

  typedef struct {
    bit          s, v, l;
    logic [31:0] w;
    bit          e_ready, e_wr;
    logic [31:0] e_addr, e_data;
    int          e_cnt;
    bit          e_run;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Basic load, ignored valid in RUN, reload, start collision, start in DRAIN.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0,        0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h20080005, 1'b1, 1'b1, 32'h0, 32'h20080005, 1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h20090007, 1'b1, 1'b1, 32'h4, 32'h20090007, 2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h01095020, 1'b1, 1'b1, 32'h8, 32'h01095020, 3, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8, 32'h01095020, 3, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h8, 32'h01095020, 3, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8, 32'h01095020, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 32'h0, 32'h11111111, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h22222222, 1'b1, 1'b1, 32'h4, 32'h22222222, 2, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b0, 32'h4, 32'h22222222, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h44444444, 1'b1, 1'b1, 32'h0, 32'h44444444, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1, 1'b1, 32'h4, 32'h55555555, 2, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h4, 32'h55555555, 2, 1'b1};

    // Reset state.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk("rst_wr",   32'(o_wr[d]),   32'h0);
      chk("rst_addr", o_addr[d],      32'h0);
      chk("rst_data", o_data[d],      32'h0);
      chk("rst_cnt",  o_cnt[d],       32'h0);
      chk("rst_cpu",  32'(o_cpu[d]),  32'h0);
      chk("rst_done", 32'(o_done[d]), 32'h0);
      chk("rst_ovf",  32'(o_ovf[d]),  32'h0);
      chk("rst_rdy",  32'(o_rdy[d]),  32'h0);
    end

    // Table-driven vectors against constant expectations.
    for (int i = 0; i < 13; i++) begin
      apply(1'b1, tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].w);
      for (int d = 0; d < 2; d++)
        chk($sformatf("tbl%0d_ready[%0d]", i, d), 32'(o_rdy[d]), 32'(tbl[i].e_ready));
      clock_edge();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d_wr[%0d]", i, d),   32'(o_wr[d]),   32'(tbl[i].e_wr));
        chk($sformatf("tbl%0d_addr[%0d]", i, d), o_addr[d],      tbl[i].e_addr);
        chk($sformatf("tbl%0d_data[%0d]", i, d), o_data[d],      tbl[i].e_data);
        chk($sformatf("tbl%0d_cnt[%0d]", i, d),  o_cnt[d],       32'(tbl[i].e_cnt));
        chk($sformatf("tbl%0d_cpu[%0d]", i, d),  32'(o_cpu[d]),  32'(tbl[i].e_run));
        chk($sformatf("tbl%0d_done[%0d]", i, d), 32'(o_done[d]), 32'(tbl[i].e_run));
        chk($sformatf("tbl%0d_ovf[%0d]", i, d),  32'(o_ovf[d]),  32'h0);
      end
    end

    // Full image on the 4-deep instance: last word at count==DEPTH-1.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 1'b1, (k == 3), 32'hA000_0000 + 32'(k));
      chk("full_wr",   32'(o_wr[1]), 32'h1);
      chk("full_addr", o_addr[1],    32'(4 * k));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("full_done", 32'(o_done[1]), 32'h1);
    chk("full_cpu",  32'(o_cpu[1]),  32'h1);
    chk("full_ovf",  32'(o_ovf[1]),  32'h0);
    chk("full_cnt",  o_cnt[1],       32'h4);

    // Overflow on the 4-deep instance: five words, no last.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 32'hB000_0000 + 32'(k));
      chk("ovf_ready", 32'(o_rdy[1]), (k == 4) ? 32'h0 : 32'h1);
      clock_edge();
    end
    chk("ovf_flag", 32'(o_ovf[1]), 32'h1);
    chk("ovf_cpu",  32'(o_cpu[1]), 32'h0);
    chk("ovf_wr",   32'(o_wr[1]),  32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hC000_0000);
      chk("ovf_sticky",  32'(o_ovf[1]), 32'h1);
      chk("ovf_nowrite", 32'(o_wr[1]),  32'h0);
      chk("ovf_cpu_low", 32'(o_cpu[1]), 32'h0);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("ovf_clear", 32'(o_ovf[1]), 32'h0);
    chk("ovf_cnt0",  o_cnt[1],      32'h0);

    // Reload from RUN drops the CPU back into reset on the next cycle.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hD000_0000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("run_cpu", 32'(o_cpu[0]), 32'h1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk("reload_cpu",  32'(o_cpu[d]),  32'h0);
      chk("reload_done", 32'(o_done[d]), 32'h0);
    end

    // Reset on the same edge a word is accepted cancels its write.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hE000_0001);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'hE000_0002);
    chk("rstacc_ready", 32'(o_rdy[0]), 32'h1);
    clock_edge();
    for (int d = 0; d < 2; d++) begin
      chk("rstacc_wr",   32'(o_wr[d]),   32'h0);
      chk("rstacc_addr", o_addr[d],      32'h0);
      chk("rstacc_data", o_data[d],      32'h0);
      chk("rstacc_cnt",  o_cnt[d],       32'h0);
      chk("rstacc_cpu",  32'(o_cpu[d]),  32'h0);
      chk("rstacc_done", 32'(o_done[d]), 32'h0);
    end

    // Reset mid-DRAIN: the CPU is never released.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hF000_0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drainrst_done", 32'(o_done[0]), 32'h0);
    chk("drainrst_cnt",  o_cnt[0],       32'h0);

    // Random stream against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
